// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - request/result bundle between the execute stage and muldiv_seq
//
// Purpose: groups the request handshake, operands and result signals of the
//          iterative multiply/divide sequencer.
// Signals (master = execute stage, slave = muldiv_seq):
//   i_req      start request, sampled only while o_busy=0
//   i_op       0 = multiply, 1 = divide
//   i_signed   signed operation (only when MULDIV_SIGNED_EN is defined)
//   i_l, i_r   multiplicand/dividend, multiplier/divisor
//   o_busy     operation in flight
//   o_valid    one-cycle result pulse
//   o_out      product low half / quotient
//   o_out_hi   product high half / remainder
//   o_dz       divide by zero flagged for the last result
//   o_flags    [0] Z, [1] N of o_out
// Configuration macro: MULDIV_SIGNED_EN

interface muldiv_seq_if #(
  parameter int RW = 16
);
  logic          i_req;
  logic          i_op;
`ifdef MULDIV_SIGNED_EN
  logic          i_signed;
`endif
  logic [RW-1:0] i_l;
  logic [RW-1:0] i_r;
  logic          o_busy;
  logic          o_valid;
  logic [RW-1:0] o_out;
  logic [RW-1:0] o_out_hi;
  logic          o_dz;
  logic [1:0]    o_flags;

  modport master (
`ifdef MULDIV_SIGNED_EN
    output i_signed,
`endif
    output i_req, i_op, i_l, i_r,
    input  o_busy, o_valid, o_out, o_out_hi, o_dz, o_flags
  );

  modport slave (
`ifdef MULDIV_SIGNED_EN
    input  i_signed,
`endif
    input  i_req, i_op, i_l, i_r,
    output o_busy, o_valid, o_out, o_out_hi, o_dz, o_flags
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative shift-add multiply / restoring divide sequencer
//
// Purpose: one bit per cycle multiply and divide sharing a single adder.
//          Result arrives with a one-cycle o_valid pulse and is held until the
//          next result is produced.
// Ports:
//   i_clk  clock, all state changes on the rising edge
//   i_rst  synchronous active-high reset, aborts any operation in flight
//   bus    muldiv_seq_if.slave (request, operands, results, flags)
// Configuration macro: MULDIV_SIGNED_EN adds i_signed and a FIXUP state that
//   applies result signs after the magnitude iteration.

module muldiv_seq #(
  parameter int RW = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  muldiv_seq_if.slave  bus
);

  localparam int CW = (RW > 1) ? $clog2(RW) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
`ifdef MULDIV_SIGNED_EN
  localparam logic [1:0] S_FIXUP = 2'd3;
`endif

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          op_q;
  logic [RW-1:0] b_q;   // multiplicand or divisor
  logic [RW-1:0] hi_q;  // product high half or partial remainder
  logic [RW-1:0] lo_q;  // multiplier bits / product low half, or dividend / quotient

  logic [RW-1:0] out_q;
  logic [RW-1:0] out_hi_q;
  logic [1:0]    flags_q;
  logic          dz_q;

  logic          div_zero;
  logic [RW-1:0] l_mag;
  logic [RW-1:0] r_mag;

  logic [RW:0]   add_a;
  logic [RW:0]   add_b;
  logic [RW+1:0] add_res;
  logic          trial_neg;
  logic [RW-1:0] step_hi;
  logic [RW-1:0] step_lo;

  function automatic logic [1:0] flags_of(input logic [RW-1:0] v);
    return {v[RW-1], (v == '0)};
  endfunction

`ifdef MULDIV_SIGNED_EN
  logic          l_neg;
  logic          r_neg;
  logic          neg_lo_q;  // negate product / quotient
  logic          neg_hi_q;  // negate remainder
  logic [RW-1:0] fix_hi;
  logic [RW-1:0] fix_lo;

  // Signed operands are iterated as magnitudes; the most-negative value maps
  // onto itself, which is its correct unsigned magnitude.
  always_comb begin
    l_neg = bus.i_signed & bus.i_l[RW-1];
    r_neg = bus.i_signed & bus.i_r[RW-1];
    l_mag = l_neg ? -bus.i_l : bus.i_l;
    r_mag = r_neg ? -bus.i_r : bus.i_r;
  end

  always_comb begin
    fix_hi = hi_q;
    fix_lo = lo_q;
    if (op_q) begin
      if (neg_lo_q) fix_lo = -lo_q;
      if (neg_hi_q) fix_hi = -hi_q;
    end else if (neg_lo_q) begin
      {fix_hi, fix_lo} = -{hi_q, lo_q};
    end
  end
`else
  always_comb begin
    l_mag = bus.i_l;
    r_mag = bus.i_r;
  end
`endif

  assign div_zero = bus.i_op && (bus.i_r == '0);

  // Single shared adder. Multiply: hi + (lo[0] ? multiplicand : 0), carry kept
  // in bit RW for the right shift. Divide: (rem:dividend-msb) - divisor, the
  // extra top bit being the borrow of the trial subtraction.
  always_comb begin
    add_a     = op_q ? {hi_q, lo_q[RW-1]} : {1'b0, hi_q};
    add_b     = (op_q || lo_q[0]) ? {1'b0, b_q} : '0;
    add_res   = {1'b0, add_a} + ({1'b0, add_b} ^ {(RW+2){op_q}})
              + {{(RW+1){1'b0}}, op_q};
    trial_neg = add_res[RW+1];
    if (op_q) begin
      // On a failed trial the shifted remainder is below the divisor, so its
      // low RW bits are the whole value.
      step_hi = trial_neg ? add_a[RW-1:0] : add_res[RW-1:0];
      step_lo = {lo_q[RW-2:0], ~trial_neg};
    end else begin
      step_hi = add_res[RW:1];
      step_lo = {add_res[0], lo_q[RW-1:1]};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      flags_q  <= 2'b00;
      dz_q     <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_req) begin
            op_q <= bus.i_op;
            dz_q <= 1'b0;
            if (div_zero) begin
              // No iteration: the fixed result is available immediately.
              state    <= S_DONE;
              out_q    <= '1;
              out_hi_q <= bus.i_l;
              flags_q  <= flags_of('1);
              dz_q     <= 1'b1;
            end else begin
              state <= S_RUN;
              cnt   <= CW'(RW - 1);
              hi_q  <= '0;
              lo_q  <= bus.i_op ? l_mag : r_mag;
              b_q   <= bus.i_op ? r_mag : l_mag;
`ifdef MULDIV_SIGNED_EN
              neg_lo_q <= l_neg ^ r_neg;
              neg_hi_q <= bus.i_op ? l_neg : (l_neg ^ r_neg);
`endif
            end
          end
        end
        S_RUN: begin
          hi_q <= step_hi;
          lo_q <= step_lo;
          if (cnt == '0) begin
`ifdef MULDIV_SIGNED_EN
            state <= S_FIXUP;
`else
            state    <= S_DONE;
            out_q    <= step_lo;
            out_hi_q <= step_hi;
            flags_q  <= flags_of(step_lo);
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef MULDIV_SIGNED_EN
        S_FIXUP: begin
          state    <= S_DONE;
          out_q    <= fix_lo;
          out_hi_q <= fix_hi;
          flags_q  <= flags_of(fix_lo);
        end
`endif
        S_DONE: state <= S_IDLE;  // a request seen here is deliberately ignored
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULDIV_SIGNED_EN
  assign bus.o_busy = (state == S_RUN) || (state == S_FIXUP);
`else
  assign bus.o_busy = (state == S_RUN);
`endif
  assign bus.o_valid  = (state == S_DONE);
  assign bus.o_out    = out_q;
  assign bus.o_out_hi = out_hi_q;
  assign bus.o_flags  = flags_q;
  assign bus.o_dz     = dz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - randomized and directed self-checking bench for muldiv_seq

module tb_muldiv_seq;
  localparam int RW = 16;
`ifdef MULDIV_SIGNED_EN
  localparam int LAT = RW + 2;
`else
  localparam int LAT = RW + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic req_signed;
  int   checks = 0;
  int   errors = 0;

  muldiv_seq_if #(.RW(RW)) bus ();
  muldiv_seq #(.RW(RW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

`ifdef MULDIV_SIGNED_EN
  assign bus.i_signed = req_signed;
`endif

  always #5 clk = ~clk;

  // Reference: {dz, hi, lo} from plain integer arithmetic.
  function automatic logic [2*RW:0] model(input logic op, input logic sgn,
                                          input logic [RW-1:0] l, input logic [RW-1:0] r);
    longint a, b, p, q, m;
    logic [RW-1:0] ones;
    ones = '1;
    if (op && r == '0) return {1'b1, l, ones};
    a = sgn ? longint'($signed(l)) : longint'(l);
    b = sgn ? longint'($signed(r)) : longint'(r);
    if (!op) begin
      p = a * b;
      return {1'b0, p[2*RW-1:0]};
    end
    q = a / b;
    m = a % b;
    return {1'b0, m[RW-1:0], q[RW-1:0]};
  endfunction

  task automatic issue(input logic op, input logic [RW-1:0] l, input logic [RW-1:0] r);
    bus.i_req = 1'b1;
    bus.i_op  = op;
    bus.i_l   = l;
    bus.i_r   = r;
    @(posedge clk); #1;
    bus.i_req = 1'b0;
  endtask

  // Entered in cycle 1 after acceptance; stops in the o_valid cycle or on budget.
  task automatic wait_valid(output int cyc, output logic seen);
    cyc  = 1;
    seen = 1'b0;
    while (cyc <= 60 && !seen) begin
      if (bus.o_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (bus.o_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.o_valid); end
    checks++; if (bus.o_dz !== 1'b0)    begin errors++; $display("FAIL reset_dz: got %b expected 0", bus.o_dz); end
    checks++; if (bus.o_out !== '0)     begin errors++; $display("FAIL reset_out: got %h expected 0", bus.o_out); end
    checks++; if (bus.o_out_hi !== '0)  begin errors++; $display("FAIL reset_out_hi: got %h expected 0", bus.o_out_hi); end
    checks++; if (bus.o_flags !== 2'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00", bus.o_flags); end
  endtask

  typedef struct {
    logic          op;
    logic          sgn;
    logic [RW-1:0] l, r, lo, hi;
    logic          dz;
    logic [1:0]    fl;
    int            lat;
  } vec_t;

  task automatic run_table(input string tag, input vec_t v [$]);
    int cyc; logic seen;
    foreach (v[i]) begin
      req_signed = v[i].sgn;
      issue(v[i].op, v[i].l, v[i].r);
      wait_valid(cyc, seen);
      checks++; if (!seen || cyc != v[i].lat) begin errors++; $display("FAIL %s[%0d]_latency: got %0d (seen=%b) expected %0d", tag, i, cyc, seen, v[i].lat); end
      checks++; if (bus.o_out !== v[i].lo)    begin errors++; $display("FAIL %s[%0d]_out: got %h expected %h", tag, i, bus.o_out, v[i].lo); end
      checks++; if (bus.o_out_hi !== v[i].hi) begin errors++; $display("FAIL %s[%0d]_out_hi: got %h expected %h", tag, i, bus.o_out_hi, v[i].hi); end
      checks++; if (bus.o_dz !== v[i].dz)     begin errors++; $display("FAIL %s[%0d]_dz: got %b expected %b", tag, i, bus.o_dz, v[i].dz); end
      checks++; if (bus.o_flags !== v[i].fl)  begin errors++; $display("FAIL %s[%0d]_flags: got %b expected %b", tag, i, bus.o_flags, v[i].fl); end
      @(posedge clk); #1;
    end
    req_signed = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v [$];
    v.push_back('{1'b0, 1'b0, 16'h1234, 16'h0010, 16'h2340, 16'h0001, 1'b0, 2'b00, LAT});
    v.push_back('{1'b1, 1'b0, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 2'b00, LAT});
    v.push_back('{1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 2'b10, LAT});
    v.push_back('{1'b1, 1'b0, 16'h0055, 16'h0000, 16'hFFFF, 16'h0055, 1'b1, 2'b10, 1});
    v.push_back('{1'b0, 1'b0, 16'd3,    16'd0,    16'h0000, 16'h0000, 1'b0, 2'b01, LAT});
    run_table("directed", v);
  endtask

`ifdef MULDIV_SIGNED_EN
  task automatic test_signed();
    vec_t v [$];
    v.push_back('{1'b1, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 2'b10, RW + 2});
    v.push_back('{1'b0, 1'b1, 16'hFFFD, 16'h0004, 16'hFFF4, 16'hFFFF, 1'b0, 2'b10, RW + 2});
    v.push_back('{1'b1, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 2'b10, RW + 2});
    v.push_back('{1'b1, 1'b1, 16'hFFF0, 16'h0000, 16'hFFFF, 16'hFFF0, 1'b1, 2'b10, 1});
    run_table("signed", v);
  endtask
`endif

  task automatic test_busy_drop();
    int busy_low = 0;
    int nvalid = 0;
    int vcyc = -1;
    logic [RW-1:0] vout = '0;
    req_signed = 1'b0;
    issue(1'b0, 16'd2, 16'd3);
    for (int cyc = 1; cyc <= LAT + 25; cyc++) begin
      if (cyc < LAT && !bus.o_busy) busy_low++;
      if (bus.o_valid) begin nvalid++; vcyc = cyc; vout = bus.o_out; end
      if (cyc == 5) begin bus.i_req = 1'b1; bus.i_op = 1'b1; bus.i_l = 16'd9; bus.i_r = 16'd3; end
      @(posedge clk); #1;
      bus.i_req = 1'b0;
    end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL drop_busy_low: got %0d cycles expected 0", busy_low); end
    checks++; if (nvalid != 1)   begin errors++; $display("FAIL drop_valid_count: got %0d expected 1", nvalid); end
    checks++; if (vcyc != LAT)   begin errors++; $display("FAIL drop_valid_cycle: got %0d expected %0d", vcyc, LAT); end
    checks++; if (vout !== 16'd6) begin errors++; $display("FAIL drop_out: got %h expected 0006", vout); end
  endtask

  task automatic test_abort();
    int nvalid = 0; int cyc; logic seen;
    req_signed = 1'b0;
    issue(1'b0, 16'hFFFF, 16'hFFFF);
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.o_busy !== 1'b0)  begin errors++; $display("FAIL abort_busy: got %b expected 0", bus.o_busy); end
    checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b expected 0", bus.o_valid); end
    checks++; if ({bus.o_out, bus.o_out_hi, bus.o_flags, bus.o_dz} !== '0) begin
      errors++; $display("FAIL abort_outputs: got %h/%h/%b/%b expected all 0", bus.o_out, bus.o_out_hi, bus.o_flags, bus.o_dz);
    end
    for (int i = 0; i < 30; i++) begin
      if (bus.o_valid) nvalid++;
      @(posedge clk); #1;
    end
    checks++; if (nvalid != 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", nvalid); end
    issue(1'b0, 16'hFFFF, 16'hFFFF);
    wait_valid(cyc, seen);
    checks++; if (!seen || bus.o_out !== 16'h0001)   begin errors++; $display("FAIL abort_fresh_out: got %h expected 0001", bus.o_out); end
    checks++; if (!seen || bus.o_out_hi !== 16'hFFFE) begin errors++; $display("FAIL abort_fresh_out_hi: got %h expected fffe", bus.o_out_hi); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int vcycs [$];
    int busy_after_done = -1;
    logic [RW-1:0] l, r;
    logic [2*RW:0] exp;
    req_signed = 1'b0;
    l = RW'($urandom);
    r = RW'($urandom);
    exp = model(1'b0, 1'b0, l, r);
    bus.i_req = 1'b1; bus.i_op = 1'b0; bus.i_l = l; bus.i_r = r;
    @(posedge clk); #1;
    for (int cyc = 1; cyc <= 3 * LAT + 2; cyc++) begin
      if (cyc == LAT + 1) busy_after_done = int'(bus.o_busy);
      if (bus.o_valid) begin
        vcycs.push_back(cyc);
        checks++; if ({bus.o_out_hi, bus.o_out} !== exp[2*RW-1:0]) begin
          errors++; $display("FAIL b2b_result: got %h%h expected %h", bus.o_out_hi, bus.o_out, exp[2*RW-1:0]);
        end
      end
      if (cyc == 3 * LAT + 2) bus.i_req = 1'b0;
      @(posedge clk); #1;
    end
    bus.i_req = 1'b0;
    for (int i = 0; i < 60 && (bus.o_busy || bus.o_valid); i++) begin @(posedge clk); #1; end
    checks++; if (vcycs.size() != 3) begin errors++; $display("FAIL b2b_pulses: got %0d expected 3", vcycs.size()); end
    checks++; if (vcycs.size() < 1 || vcycs[0] != LAT) begin errors++; $display("FAIL b2b_first: got %0d expected %0d", (vcycs.size() > 0) ? vcycs[0] : -1, LAT); end
    for (int i = 1; i < vcycs.size(); i++) begin
      checks++; if (vcycs[i] - vcycs[i-1] != LAT + 1) begin errors++; $display("FAIL b2b_gap: got %0d expected %0d", vcycs[i] - vcycs[i-1], LAT + 1); end
    end
    checks++; if (busy_after_done != 0) begin errors++; $display("FAIL b2b_done_req_ignored: busy got %0d expected 0", busy_after_done); end
  endtask

  task automatic test_random();
    int cyc; logic seen;
    logic op;
    logic [RW-1:0] l, r;
    logic [2*RW:0] exp;
    int exp_lat;
    for (int n = 0; n < 48; n++) begin
      op = 1'($urandom_range(0, 1));
      l  = RW'($urandom);
      r  = ($urandom_range(0, 7) == 0) ? '0 : RW'($urandom);
      if (n % 4 == 1) r = RW'($urandom_range(1, 5));
`ifdef MULDIV_SIGNED_EN
      req_signed = 1'($urandom_range(0, 1));
`else
      req_signed = 1'b0;
`endif
      exp = model(op, req_signed, l, r);
      exp_lat = (op && r == '0) ? 1 : LAT;
      issue(op, l, r);
      bus.i_l = RW'($urandom);
      bus.i_r = RW'($urandom);
      bus.i_op = ~op;
      wait_valid(cyc, seen);
      checks++; if (!seen || cyc != exp_lat) begin errors++; $display("FAIL rand[%0d]_latency: got %0d expected %0d", n, cyc, exp_lat); end
      checks++; if (bus.o_out !== exp[RW-1:0])       begin errors++; $display("FAIL rand[%0d]_out: op=%b s=%b %h,%h got %h expected %h", n, op, req_signed, l, r, bus.o_out, exp[RW-1:0]); end
      checks++; if (bus.o_out_hi !== exp[2*RW-1:RW]) begin errors++; $display("FAIL rand[%0d]_out_hi: op=%b s=%b %h,%h got %h expected %h", n, op, req_signed, l, r, bus.o_out_hi, exp[2*RW-1:RW]); end
      checks++; if (bus.o_dz !== exp[2*RW])          begin errors++; $display("FAIL rand[%0d]_dz: got %b expected %b", n, bus.o_dz, exp[2*RW]); end
      checks++; if (bus.o_flags !== {exp[RW-1], exp[RW-1:0] == '0}) begin
        errors++; $display("FAIL rand[%0d]_flags: got %b expected %b", n, bus.o_flags, {exp[RW-1], exp[RW-1:0] == '0});
      end
      @(posedge clk); #1;
      checks++; if (bus.o_valid !== 1'b0 || bus.o_out !== exp[RW-1:0] || bus.o_out_hi !== exp[2*RW-1:RW]) begin
        errors++; $display("FAIL rand[%0d]_hold: valid %b out %h/%h expected 0 %h/%h", n, bus.o_valid, bus.o_out_hi, bus.o_out, exp[2*RW-1:RW], exp[RW-1:0]);
      end
    end
    req_signed = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_signed = 1'b0;
    bus.i_req = 1'b0;
    bus.i_op = 1'b0;
    bus.i_l = '0;
    bus.i_r = '0;
    test_reset();
    test_directed();
    test_busy_drop();
    test_abort();
    test_back_to_back();
    test_random();
`ifdef MULDIV_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
